trans_matrix_loader: RTL and testbench
======================================

TRANS_MATRIX_LOADER -- requirements
Module: trans_matrix_loader

Interface
REQ-001 SHALL take parameter DATA_PREC, default from defs.sv; width of one fixed-point entry.
REQ-002 SHALL take parameter HIDDEN_STATES, default from defs.sv; matrix dimension N (N >= 2).
REQ-003 SHALL take parameter RIGHT_DEC_BITS, default from defs.sv; fractional bits, so 1.0 = 1<<RIGHT_DEC_BITS.
REQ-004 SHALL take parameter ROW_SUM_TOL, default 1; allowed absolute row-sum error in LSBs.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  in_data holds a valid entry.
REQ-008 in_data  input  DATA_PREC  matrix entry, streamed row-major.
REQ-009 in_ready  output  1  loader can accept an entry this cycle.
REQ-010 reload  input  1  single-cycle pulse that restarts loading.
REQ-011 trans  output  [DATA_PREC-1:0] [N-1:0][N-1:0]  registered transition matrix, feeding stationary_state.trans directly.
REQ-012 trans_valid  output  1  full matrix loaded; trans is stable.
REQ-013 row_err  output  1  sticky row-sum error flag.

Function
REQ-014 SHALL implement a two-state FSM, LOAD and DONE; there is no other state.
REQ-015 in_ready SHALL equal (state==LOAD) && !reload, combinationally.
REQ-016 An entry SHALL be accepted only on a clk edge where in_valid && in_ready; no other cycle changes trans.
REQ-017 An accepted entry SHALL be written to trans[row][col] and visible on trans one cycle after acceptance.
REQ-018 After each accept, col SHALL increment; at col==N-1, col SHALL wrap to 0 and row SHALL increment.
REQ-019 Accepting entry (N-1,N-1) SHALL move the FSM to DONE and set trans_valid=1 on the same edge; in_ready SHALL be 0 from the next cycle.
REQ-020 In DONE, trans and trans_valid SHALL hold; in_valid SHALL be ignored.
REQ-021 reload in any state SHALL, on the next edge: set row=col=0, clear trans_valid and row_err, and enter LOAD. trans contents are retained until overwritten.
REQ-022 reload asserted together with in_valid SHALL win: the beat is not accepted, because in_ready is 0.
REQ-023 in_valid gaps of any length SHALL not lose or duplicate entries.
REQ-024 Entries are treated as unsigned; the loader SHALL perform no saturation or normalization.

Reset
REQ-025 On rst=1, the block SHALL immediately and asynchronously set: state=LOAD, row=col=0, every trans entry=0, trans_valid=0, row_err=0.
REQ-026 Reset asserted mid-load SHALL discard the partial matrix; loading SHALL restart at (0,0) after release.
REQ-027 in_ready SHALL be 1 in the first cycle after release when reload=0.

Configuration
REQ-028 Macro ROW_SUM_CHECK_EN SHALL compile in the row-sum checker.
REQ-029 With ROW_SUM_CHECK_EN defined:
- an accumulator of width DATA_PREC+$clog2(N) SHALL sum each row's accepted entries;
- it SHALL clear at col wrap, on reload and on reset;
- on acceptance of each row's last entry, if |sum - (1<<RIGHT_DEC_BITS)| > ROW_SUM_TOL, row_err SHALL set on that edge;
- row_err SHALL stay set until reload or rst.
REQ-030 Without ROW_SUM_CHECK_EN, no accumulator SHALL exist and row_err SHALL be tied to 0; the port list SHALL be unchanged.

Verification (N=2, DATA_PREC=16, RIGHT_DEC_BITS=8, ROW_SUM_TOL=1, macro defined unless stated)
REQ-031 Stream 128,128,64,192 back-to-back from reset -> trans={{128,128},{64,192}}, trans_valid=1 on the edge of the 4th accept, in_ready=0 the following cycle, row_err=0.
REQ-032 Stream 128,126,0,256 -> row_err=1 from the 2nd accept edge, sticky through DONE; repeat with 128,127 -> row_err=0 (within tolerance).
REQ-033 Same stream with in_valid deasserted 3 cycles between beats, plus one extra beat during DONE -> identical trans, extra beat ignored.
REQ-034 reload pulsed with in_valid=1 after 2 accepts, then stream 10,246,246,10 -> reload beat rejected, trans={{10,246},{246,10}}, trans_valid and row_err cleared then trans_valid=1.
REQ-035 rst asserted after 3 accepts -> all trans=0, trans_valid=0 immediately, without waiting for a clock edge; a new 4-beat stream loads from (0,0).
REQ-036 Macro undefined, stream 0,0,0,0 -> trans_valid=1, row_err=0.

Source files
------------

// File: rtl/trans_matrix_loader.sv
// trans_matrix_loader: streams an N x N fixed-point transition matrix
// (row-major, valid/ready) into a register array that drives the
// stationary-state solver directly.
// Optional feature: define ROW_SUM_CHECK_EN to build the row-sum checker,
// which flags any row whose sum is further than ROW_SUM_TOL LSBs from 1.0.
// Without it, row_err is tied low and no accumulator is built.
// Parameter defaults match the project-wide definitions (16-bit entries,
// 8 fractional bits).
//
// state | meaning
// LOAD  | accepting entries, trans is partial
// DONE  | full matrix held, trans_valid high, input ignored

module trans_matrix_loader #(
  parameter int DATA_PREC      = 16,
  parameter int HIDDEN_STATES  = 4,
  parameter int RIGHT_DEC_BITS = 8,
  parameter int ROW_SUM_TOL    = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 in_valid,
  input  logic [DATA_PREC-1:0]                                 in_data,
  output logic                                                 in_ready,
  input  logic                                                 reload,
  output logic [HIDDEN_STATES-1:0][HIDDEN_STATES-1:0][DATA_PREC-1:0] trans,
  output logic                                                 trans_valid,
  output logic                                                 row_err
);

  localparam int RC_W = $clog2(HIDDEN_STATES);
  localparam logic [RC_W-1:0] LAST = RC_W'(HIDDEN_STATES - 1);

  // N below 2, a negative tolerance, or 1.0 not fitting the row-sum width
  // would make the loader meaningless; stop at elaboration instead.
  if (HIDDEN_STATES < 2 || ROW_SUM_TOL < 0 ||
      RIGHT_DEC_BITS >= DATA_PREC + $clog2(HIDDEN_STATES)) begin : g_bad_params
    $error("trans_matrix_loader: illegal parameter combination");
  end

  typedef enum logic {LOAD = 1'b0, DONE = 1'b1} state_t;

  state_t          state, state_n;
  logic [RC_W-1:0] row, col;
  logic            accept;
  logic            last_entry;

  assign accept     = in_valid && in_ready;
  assign last_entry = (row == LAST) && (col == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  // Next state: reload always returns to LOAD; the final entry completes the matrix
  always_comb begin
    state_n = state;
    if (reload)
      state_n = LOAD;
    else if (state == LOAD && accept && last_entry)
      state_n = DONE;
  end

  // Outputs decoded from state; reload blocks acceptance in the same cycle
  always_comb begin
    in_ready    = (state == LOAD) && !reload;
    trans_valid = (state == DONE);
  end

  // Row/column write pointer, row-major with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (reload) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Matrix storage; reload keeps old contents until they are overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      trans <= '0;
    else if (accept)
      trans[row][col] <= in_data;
  end

`ifdef ROW_SUM_CHECK_EN
  localparam int ACC_W = DATA_PREC + $clog2(HIDDEN_STATES);
  localparam logic [ACC_W:0] ONE = (ACC_W + 1)'(1) << RIGHT_DEC_BITS;
  localparam logic [ACC_W:0] TOL = (ACC_W + 1)'(ROW_SUM_TOL);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   row_sum;
  logic [ACC_W:0]   err_mag;
  logic             row_bad;

  // Sum including the entry being accepted, so the last entry is judged on its own edge
  always_comb begin
    row_sum = {1'b0, acc} + (ACC_W + 1)'(in_data);
    err_mag = (row_sum >= ONE) ? (row_sum - ONE) : (ONE - row_sum);
    row_bad = (err_mag > TOL);
  end

  // Per-row accumulator and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      row_err <= 1'b0;
    end else if (reload) begin
      acc     <= '0;
      row_err <= 1'b0;
    end else if (accept) begin
      if (col == LAST) begin
        acc <= '0;
        if (row_bad) row_err <= 1'b1;
      end else begin
        acc <= row_sum[ACC_W-1:0];
      end
    end
  end
`else
  assign row_err = 1'b0;
`endif

endmodule

// File: tb/tb_trans_matrix_loader.sv
// Bench for trans_matrix_loader with N=2, 16-bit entries, 8 fractional bits.
// Accepted beats are pushed to a scoreboard when driven and popped after the
// accepting edge; a small reference model tracks state and row sums.

module tb_trans_matrix_loader;

  localparam int N   = 2;
  localparam int DP  = 16;
  localparam int RDB = 8;
  localparam int TOL = 1;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [DP-1:0] in_data;
  logic in_ready;
  logic reload;
  logic [N-1:0][N-1:0][DP-1:0] trans;
  logic trans_valid;
  logic row_err;

  trans_matrix_loader #(
    .DATA_PREC(DP), .HIDDEN_STATES(N), .RIGHT_DEC_BITS(RDB), .ROW_SUM_TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .trans(trans),
    .trans_valid(trans_valid), .row_err(row_err)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int c; logic [DP-1:0] d;} beat_t;
  beat_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  bit m_done;
  bit m_err;
  int m_row, m_col, m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit err_enabled();
`ifdef ROW_SUM_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    m_done = 0; m_err = 0; m_row = 0; m_col = 0; m_acc = 0;
  endtask

  // One clock cycle: drive, predict acceptance, advance, then check.
  task automatic cycle(input bit v, input logic [DP-1:0] d, input bit rl);
    bit acc;
    beat_t b;
    int diff;
    in_valid = v; in_data = d; reload = rl;
    #1;
    acc = v && !m_done && !rl;
    check("in_ready", {31'b0, in_ready}, {31'b0, (!m_done && !rl)});
    if (acc) sb.push_back('{m_row, m_col, d});
    @(posedge clk); #1;
    if (rl) begin
      model_clear();
    end else if (acc) begin
      m_acc += int'(d);
      if (m_col == N-1) begin
        diff = m_acc - (1 << RDB);
        if (diff < 0) diff = -diff;
        if (diff > TOL && err_enabled()) m_err = 1;
        m_acc = 0;
        m_col = 0;
        if (m_row == N-1) begin m_done = 1; m_row = 0; end
        else m_row++;
      end else begin
        m_col++;
      end
    end
    if (sb.size() > 0) begin
      b = sb.pop_front();
      check("trans_entry", {16'b0, trans[b.r][b.c]}, {16'b0, b.d});
    end
    check("trans_valid", {31'b0, trans_valid}, {31'b0, m_done});
    check("row_err", {31'b0, row_err}, {31'b0, m_err});
    in_valid = 1'b0; reload = 1'b0;
  endtask

  task automatic stream4(input int a, input int b, input int c, input int e, input int gap);
    int vals[4];
    vals = '{a, b, c, e};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, DP'(vals[i]), 1'b0);
      if (i < 3) for (int g = 0; g < gap; g++) cycle(1'b0, '0, 1'b0);
    end
  endtask

  task automatic check_matrix(input string tag, input int a, input int b, input int c, input int e);
    check({tag, "_00"}, {16'b0, trans[0][0]}, a);
    check({tag, "_01"}, {16'b0, trans[0][1]}, b);
    check({tag, "_10"}, {16'b0, trans[1][0]}, c);
    check({tag, "_11"}, {16'b0, trans[1][1]}, e);
  endtask

  // Reset asserted between edges; effect must be visible before any edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    check_matrix("rst_trans", 0, 0, 0, 0);
    check("rst_trans_valid", {31'b0, trans_valid}, 0);
    check("rst_row_err", {31'b0, row_err}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    sb.delete();
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; reload = 1'b0;
    model_clear();
    @(posedge clk); #1;
    async_reset();

    // Back-to-back load from reset
    stream4(128, 128, 64, 192, 0);
    cycle(1'b0, '0, 1'b0);
    check_matrix("s1", 128, 128, 64, 192);

    // Out-of-tolerance row 0, then a within-tolerance row
    cycle(1'b0, '0, 1'b1);
    stream4(128, 126, 0, 256, 0);
    cycle(1'b0, '0, 1'b0);
    check("s2_err_sticky", {31'b0, row_err}, {31'b0, err_enabled()});
    cycle(1'b0, '0, 1'b1);
    stream4(128, 127, 0, 256, 0);
    check_matrix("s2b", 128, 127, 0, 256);

    // Gapped stream plus an ignored beat in DONE
    cycle(1'b0, '0, 1'b1);
    stream4(128, 128, 64, 192, 3);
    cycle(1'b1, DP'(999), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check_matrix("s3", 128, 128, 64, 192);

    // Reload colliding with a valid beat mid-load
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, DP'(1), 1'b0);
    cycle(1'b1, DP'(2), 1'b0);
    cycle(1'b1, DP'(999), 1'b1);
    stream4(10, 246, 246, 10, 0);
    check_matrix("s4", 10, 246, 246, 10);

    // Asynchronous reset after three accepts, then a fresh load
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, DP'(5), 1'b0);
    cycle(1'b1, DP'(6), 1'b0);
    cycle(1'b1, DP'(7), 1'b0);
    async_reset();
    stream4(1, 255, 255, 1, 1);
    check_matrix("s5", 1, 255, 255, 1);

    // All-zero matrix: row error only when the checker is built
    cycle(1'b0, '0, 1'b1);
    stream4(0, 0, 0, 0, 0);
    check_matrix("s6", 0, 0, 0, 0);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
